// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 key-search scheduler: FSM states,
// S-port owner encoding and the phase classification helpers.
package rc4_pkg;

   localparam int          RC4_KEY_WIDTH      = 24;
   localparam logic [23:0] RC4_KEY_FIRST      = 24'h000000;
   localparam logic [23:0] RC4_KEY_LAST       = 24'h3FFFFF;
   localparam int          RC4_TIMEOUT_CYCLES = 4096;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT_GO,
      ST_INIT_WAIT,
      ST_KSA_GO,
      ST_KSA_WAIT,
      ST_DEC_GO,
      ST_DEC_WAIT,
      ST_NEXT_KEY,
      ST_FOUND,
      ST_EXHAUSTED,
      ST_ERROR
   } sched_state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_INIT,
      OWN_KSA,
      OWN_DEC
   } s_owner_t;

   // The engine that owns the S port for the whole of its GO and WAIT states.
   function automatic s_owner_t owner_for_state(input sched_state_t st);
      s_owner_t own;
      case (st)
         ST_INIT_GO, ST_INIT_WAIT: own = OWN_INIT;
         ST_KSA_GO,  ST_KSA_WAIT:  own = OWN_KSA;
         ST_DEC_GO,  ST_DEC_WAIT:  own = OWN_DEC;
         default:                  own = OWN_NONE;
      endcase
      return own;
   endfunction

   function automatic logic is_go_state(input sched_state_t st);
      return (st == ST_INIT_GO) || (st == ST_KSA_GO) || (st == ST_DEC_GO);
   endfunction

   function automatic logic is_wait_state(input sched_state_t st);
      return (st == ST_INIT_WAIT) || (st == ST_KSA_WAIT) || (st == ST_DEC_WAIT);
   endfunction

endpackage

// File: rtl/rc4_s_port_mux.sv
// Combinational 3:1 mux granting the single S-memory port to one engine.
// Non-owner requests are dropped entirely; no owner drives all zeros.
module rc4_s_port_mux
   import rc4_pkg::*;
(
   input  s_owner_t   owner,
   input  logic [7:0] init_addr,
   input  logic [7:0] init_data,
   input  logic       init_wren,
   input  logic [7:0] ksa_addr,
   input  logic [7:0] ksa_data,
   input  logic       ksa_wren,
   input  logic [7:0] dec_addr,
   input  logic [7:0] dec_data,
   input  logic       dec_wren,
   output logic [7:0] s_address,
   output logic [7:0] s_data,
   output logic       s_wren
);

   always_comb begin
      s_address = 8'h00;
      s_data    = 8'h00;
      s_wren    = 1'b0;
      case (owner)
         OWN_INIT: begin
            s_address = init_addr;
            s_data    = init_data;
            s_wren    = init_wren;
         end
         OWN_KSA: begin
            s_address = ksa_addr;
            s_data    = ksa_data;
            s_wren    = ksa_wren;
         end
         OWN_DEC: begin
            s_address = dec_addr;
            s_data    = dec_data;
            s_wren    = dec_wren;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/rc4_crack_scheduler.sv
// Key-search sequencer: runs init -> ksa -> decrypt per candidate key and owns the S port.
// Define RC4_SCHED_WATCHDOG_EN to add the per-phase watchdog and the ERROR state.
module rc4_crack_scheduler
   import rc4_pkg::*;
#(
   parameter int                   KEY_WIDTH      = RC4_KEY_WIDTH,
   parameter logic [KEY_WIDTH-1:0] KEY_FIRST      = KEY_WIDTH'(RC4_KEY_FIRST),
   parameter logic [KEY_WIDTH-1:0] KEY_LAST       = KEY_WIDTH'(RC4_KEY_LAST),
   parameter int                   TIMEOUT_CYCLES = RC4_TIMEOUT_CYCLES
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic [KEY_WIDTH-1:0] key,
   output logic                 init_start,
   output logic                 ksa_start,
   output logic                 dec_start,
   input  logic                 init_finish,
   input  logic                 ksa_finish,
   input  logic                 dec_finish,
   input  logic                 dec_match,
   input  logic [7:0]           init_addr,
   input  logic [7:0]           init_data,
   input  logic                 init_wren,
   input  logic [7:0]           ksa_addr,
   input  logic [7:0]           ksa_data,
   input  logic                 ksa_wren,
   input  logic [7:0]           dec_addr,
   input  logic [7:0]           dec_data,
   input  logic                 dec_wren,
   output logic [7:0]           s_address,
   output logic [7:0]           s_data,
   output logic                 s_wren,
   output logic                 busy,
   output logic                 found,
   output logic                 exhausted,
   output logic                 err
);

   sched_state_t         state_reg, state_next;
   logic [KEY_WIDTH-1:0] key_reg, key_next;
   s_owner_t             owner_reg;
   logic                 wd_expired;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         key_reg   <= KEY_FIRST;
         owner_reg <= OWN_NONE;
      end else begin
         state_reg <= state_next;
         key_reg   <= key_next;
         // Owner is registered alongside the state so the grant never glitches.
         owner_reg <= owner_for_state(state_next);
      end
   end

   always_comb begin
      state_next = state_reg;
      key_next   = key_reg;
      case (state_reg)
         ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_ERROR: begin
            if (start) begin
               key_next   = KEY_FIRST;
               state_next = ST_INIT_GO;
            end
         end
         ST_INIT_GO: state_next = ST_INIT_WAIT;
         ST_INIT_WAIT: begin
            if (init_finish)     state_next = ST_KSA_GO;
            else if (wd_expired) state_next = ST_ERROR;
         end
         ST_KSA_GO: state_next = ST_KSA_WAIT;
         ST_KSA_WAIT: begin
            if (ksa_finish)      state_next = ST_DEC_GO;
            else if (wd_expired) state_next = ST_ERROR;
         end
         ST_DEC_GO: state_next = ST_DEC_WAIT;
         ST_DEC_WAIT: begin
            if (dec_finish) begin
               if (dec_match)              state_next = ST_FOUND;
               else if (key_reg == KEY_LAST) state_next = ST_EXHAUSTED;
               else                        state_next = ST_NEXT_KEY;
            end else if (wd_expired) begin
               state_next = ST_ERROR;
            end
         end
         ST_NEXT_KEY: begin
            key_next   = key_reg + KEY_WIDTH'(1);
            state_next = ST_INIT_GO;
         end
         default: state_next = ST_IDLE;
      endcase
   end

`ifdef RC4_SCHED_WATCHDOG_EN
   localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wd_cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt_reg <= '0;
      end else if (is_go_state(state_reg)) begin
         wd_cnt_reg <= '0;
      end else if (is_wait_state(state_reg)) begin
         wd_cnt_reg <= wd_cnt_reg + 16'd1;
      end
   end

   assign wd_expired = (wd_cnt_reg == WD_LIMIT);
   assign err        = (state_reg == ST_ERROR);
`else
   assign wd_expired = 1'b0;
   assign err        = 1'b0;
`endif

   assign key        = key_reg;
   assign init_start = (state_reg == ST_INIT_GO);
   assign ksa_start  = (state_reg == ST_KSA_GO);
   assign dec_start  = (state_reg == ST_DEC_GO);
   assign busy       = is_go_state(state_reg) || is_wait_state(state_reg) ||
                       (state_reg == ST_NEXT_KEY);
   assign found      = (state_reg == ST_FOUND);
   assign exhausted  = (state_reg == ST_EXHAUSTED);

   rc4_s_port_mux u_s_port_mux (
      .owner     (owner_reg),
      .init_addr (init_addr),
      .init_data (init_data),
      .init_wren (init_wren),
      .ksa_addr  (ksa_addr),
      .ksa_data  (ksa_data),
      .ksa_wren  (ksa_wren),
      .dec_addr  (dec_addr),
      .dec_data  (dec_data),
      .dec_wren  (dec_wren),
      .s_address (s_address),
      .s_data    (s_data),
      .s_wren    (s_wren)
   );

endmodule

// File: tb/tb_rc4_crack_scheduler.sv
// Self-checking bench: behavioural engine responders and an expected-outcome model per search.
module tb_rc4_crack_scheduler;

   localparam int KW    = 24;
   localparam int KLAST = 3;
   localparam int NKEYS = KLAST + 1;

   logic          clk = 1'b0;
   logic          reset, start;
   logic [KW-1:0] key;
   logic          init_start, ksa_start, dec_start;
   logic          init_finish, ksa_finish, dec_finish, dec_match;
   logic [7:0]    init_addr, init_data, ksa_addr, ksa_data, dec_addr, dec_data;
   logic          init_wren, ksa_wren, dec_wren;
   logic [7:0]    s_address, s_data;
   logic          s_wren, busy, found, exhausted, err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rc4_crack_scheduler #(
      .KEY_WIDTH      (KW),
      .KEY_FIRST      (24'd0),
      .KEY_LAST       (24'(KLAST)),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .key         (key),
      .init_start  (init_start),
      .ksa_start   (ksa_start),
      .dec_start   (dec_start),
      .init_finish (init_finish),
      .ksa_finish  (ksa_finish),
      .dec_finish  (dec_finish),
      .dec_match   (dec_match),
      .init_addr   (init_addr),
      .init_data   (init_data),
      .init_wren   (init_wren),
      .ksa_addr    (ksa_addr),
      .ksa_data    (ksa_data),
      .ksa_wren    (ksa_wren),
      .dec_addr    (dec_addr),
      .dec_data    (dec_data),
      .dec_wren    (dec_wren),
      .s_address   (s_address),
      .s_data      (s_data),
      .s_wren      (s_wren),
      .busy        (busy),
      .found       (found),
      .exhausted   (exhausted),
      .err         (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_quiet();
      start = 0; init_finish = 0; ksa_finish = 0; dec_finish = 0; dec_match = 0;
      init_addr = 0; init_data = 0; init_wren = 0;
      ksa_addr = 0; ksa_data = 0; ksa_wren = 0;
      dec_addr = 0; dec_data = 0; dec_wren = 0;
   endtask

   task automatic randomize_ports();
      init_addr = 8'($urandom); init_data = 8'($urandom); init_wren = 1'($urandom);
      ksa_addr  = 8'($urandom); ksa_data  = 8'($urandom); ksa_wren  = 1'($urandom);
      dec_addr  = 8'($urandom); dec_data  = 8'($urandom); dec_wren  = 1'($urandom);
   endtask

   task automatic test_reset();
      drive_quiet();
      reset = 1;
      tick();
      tick();
      checks++; if (key !== 24'd0) begin errors++; $display("FAIL reset_key got %0h exp 0", key); end
      checks++; if ({init_start, ksa_start, dec_start} !== 3'b000) begin errors++; $display("FAIL reset_starts got %b exp 000", {init_start, ksa_start, dec_start}); end
      checks++; if ({busy, found, exhausted, err} !== 4'b0000) begin errors++; $display("FAIL reset_status got %b exp 0000", {busy, found, exhausted, err}); end
      randomize_ports();
      #1;
      checks++; if ({s_address, s_data, s_wren} !== 17'd0) begin errors++; $display("FAIL reset_port got %h/%h/%b exp 0/0/0", s_address, s_data, s_wren); end
      reset = 0;
      drive_quiet();
      tick();
      checks++; if ({busy, init_start} !== 2'b00) begin errors++; $display("FAIL idle_no_start got busy/init_start %b exp 00", {busy, init_start}); end
   endtask

   // Drives one complete search. li/lk/ld = WAIT-state length per phase, match_key < 0 means none
   // matches. abort_key >= 0 applies reset during KSA_WAIT of that key instead of finishing.
   task automatic run_search(input string name, input int li, input int lk, input int ld,
                             input int match_key, input int abort_key);
      int   i_cnt = -1, k_cnt = -1, d_cnt = -1;
      int   phase = 0;
      int   n_i = 0, n_k = 0, n_d = 0;
      int   busy_cycles = 0, cyc = 0;
      int   keys_seen[$];
      int   exp_n, exp_cycles;
      bit   exp_found, done = 0, real_fin;
      logic [16:0] exp_port;

      if (match_key >= 0 && match_key <= KLAST) begin
         exp_found = 1; exp_n = match_key + 1;
      end else begin
         exp_found = 0; exp_n = NKEYS;
      end
      exp_cycles = exp_n * (3 + li + lk + ld) + exp_n - 1;

      start = 1;
      while (!done && cyc < 20000) begin
         tick();
         cyc++;
         start = 0; init_finish = 0; ksa_finish = 0; dec_finish = 0;
         dec_match = 1'($urandom);
         real_fin = 0;
         if (cyc == 1) begin
            checks++;
            if ({init_start, busy, found, exhausted, err} !== 5'b11000 || key !== 24'd0) begin
               errors++;
               $display("FAIL %s start_latency got start/busy/found/exh/err %b key %0h exp 11000 key 0",
                        name, {init_start, busy, found, exhausted, err}, key);
            end
         end
         if (!busy) begin
            done = 1;
            break;
         end
         busy_cycles++;

         if (init_start) begin n_i++; phase = 1; i_cnt = 0; end
         else if (i_cnt >= 0) begin
            i_cnt++;
            if (i_cnt == li) begin init_finish = 1; real_fin = 1; i_cnt = -1; end
         end
         if (ksa_start) begin n_k++; phase = 2; k_cnt = 0; end
         else if (k_cnt >= 0) begin
            k_cnt++;
            if (k_cnt == lk) begin ksa_finish = 1; real_fin = 1; k_cnt = -1; end
         end
         if (dec_start) begin n_d++; phase = 3; d_cnt = 0; keys_seen.push_back(int'(key)); end
         else if (d_cnt >= 0) begin
            d_cnt++;
            if (d_cnt == ld) begin
               dec_finish = 1; real_fin = 1; d_cnt = -1;
               dec_match = (match_key >= 0 && int'(key) == match_key);
            end
         end

         // Stray finishes from engines that are not waiting must be ignored.
         if (phase != 1 || i_cnt == 0) init_finish = ($urandom_range(0, 3) == 0);
         if (phase != 2 || k_cnt == 0) ksa_finish  = ($urandom_range(0, 3) == 0);
         if (phase != 3 || d_cnt == 0) dec_finish  = ($urandom_range(0, 3) == 0);

         randomize_ports();

         if (abort_key >= 0 && phase == 2 && k_cnt == 1 && int'(key) == abort_key) begin
            ksa_wren = 1; ksa_finish = 0; reset = 1;
            #1;
            checks++; if (s_wren !== 1'b1 || s_address !== ksa_addr) begin errors++; $display("FAIL %s abort_pre got wren %b addr %h exp 1 %h", name, s_wren, s_address, ksa_addr); end
            tick();
            checks++; if (s_wren !== 1'b0 || s_address !== 8'h00) begin errors++; $display("FAIL %s abort_port got wren %b addr %h exp 0 00", name, s_wren, s_address); end
            checks++; if (busy !== 1'b0 || key !== 24'd0 || ksa_start !== 1'b0) begin errors++; $display("FAIL %s abort_state got busy %b key %0h ksa_start %b exp 0 0 0", name, busy, key, ksa_start); end
            reset = 0;
            drive_quiet();
            tick();
            return;
         end

         case (phase)
            1:       exp_port = {init_addr, init_data, init_wren};
            2:       exp_port = {ksa_addr, ksa_data, ksa_wren};
            3:       exp_port = {dec_addr, dec_data, dec_wren};
            default: exp_port = 17'd0;
         endcase
         #1;
         checks++;
         if ({s_address, s_data, s_wren} !== exp_port) begin
            errors++;
            $display("FAIL %s port cyc %0d phase %0d got %h/%h/%b exp %h/%h/%b", name, cyc, phase,
                     s_address, s_data, s_wren, exp_port[16:9], exp_port[8:1], exp_port[0]);
         end
         if (real_fin) phase = 0;
      end
      drive_quiet();

      checks++; if (!done) begin errors++; $display("FAIL %s timeout got busy after %0d cycles exp idle", name, cyc); end
      checks++; if (found !== exp_found || exhausted !== !exp_found) begin errors++; $display("FAIL %s outcome got found %b exh %b exp %b %b", name, found, exhausted, exp_found, !exp_found); end
      checks++; if (int'(key) != exp_n - 1) begin errors++; $display("FAIL %s final_key got %0d exp %0d", name, key, exp_n - 1); end
      checks++; if (n_i != exp_n || n_k != exp_n || n_d != exp_n) begin errors++; $display("FAIL %s pulses got %0d/%0d/%0d exp %0d each", name, n_i, n_k, n_d, exp_n); end
      checks++; if (busy_cycles != exp_cycles) begin errors++; $display("FAIL %s busy_cycles got %0d exp %0d", name, busy_cycles, exp_cycles); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s err got %b exp 0", name, err); end
      for (int i = 0; i < exp_n; i++) begin
         checks++;
         if (i >= keys_seen.size() || keys_seen[i] != i) begin
            errors++;
            $display("FAIL %s key_order idx %0d got %0d exp %0d", name, i,
                     (i < keys_seen.size()) ? keys_seen[i] : -1, i);
         end
      end
      $display("%s: li %0d lk %0d ld %0d match %0d -> found %b exhausted %b key %0d busy_cycles %0d",
               name, li, lk, ld, match_key, found, exhausted, key, busy_cycles);
   endtask

   // Init finishes immediately, ksa never finishes.
   task automatic test_withhold();
      int  g = -1;
      int  ksa_pulses = 0;
      bit  ok = 1;
      bit  err_seen = 0;
      drive_quiet();
      start = 1;
      for (int c = 0; c < 60; c++) begin
         tick();
         start = 0;
         init_finish = (g < 0 && !init_start && !ksa_start);
         if (ksa_start) begin ksa_pulses++; if (g < 0) g = c; end
         if (g >= 0 && c > g) begin
`ifdef RC4_SCHED_WATCHDOG_EN
            if (c <= g + 10 && err !== 1'b0) ok = 0;
            if (err === 1'b1 && busy === 1'b0) err_seen = 1;
`else
            if (err !== 1'b0 || busy !== 1'b1) ok = 0;
`endif
         end
      end
`ifdef RC4_SCHED_WATCHDOG_EN
      checks++; if (!ok || !err_seen) begin errors++; $display("FAIL withhold_watchdog got early_ok %b err_seen %b exp 1 1", ok, err_seen); end
      checks++; if (key !== 24'd0) begin errors++; $display("FAIL withhold_key got %0h exp 0", key); end
      start = 1;
      tick();
      start = 0;
      checks++; if (err !== 1'b0 || init_start !== 1'b1) begin errors++; $display("FAIL withhold_restart got err %b init_start %b exp 0 1", err, init_start); end
`else
      checks++; if (!ok) begin errors++; $display("FAIL withhold_wait got err/busy not 0/1 (err %b busy %b)", err, busy); end
      checks++; if (ksa_pulses != 1 || g < 0) begin errors++; $display("FAIL withhold_pulses got %0d exp 1", ksa_pulses); end
`endif
      $display("withhold: ksa_start at cycle %0d err %b busy %b", g, err, busy);
      drive_quiet();
      reset = 1;
      tick();
      reset = 0;
      checks++; if ({busy, err, found, exhausted} !== 4'b0000) begin errors++; $display("FAIL withhold_reset got %b exp 0000", {busy, err, found, exhausted}); end
   endtask

   initial begin
      reset = 1;
      drive_quiet();
      test_reset();
      run_search("spec_first", 256, 768, 64, 0, -1);
      run_search("exhaust", $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6), -1, -1);
      run_search("match2", $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6), 2, -1);
      run_search("restart", 1, 1, 1, -1, -1);
      for (int r = 0; r < 5; r++) begin
         run_search("random", $urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(1, 9),
                    int'($urandom_range(0, 5)) - 1, -1);
      end
      run_search("back_to_back", 2, 1, 3, 1, -1);
      run_search("abort", 2, 3, 2, -1, 2);
      test_withhold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rc4_crack_scheduler.md
# rc4_crack_scheduler

Top-level sequencer for the RC4 key-search datapath. It steps each candidate key through three phase engines: S-memory initializer, key-scheduling shuffler, decrypt/check. It owns the single-port S memory and grants its address, data and write-enable to exactly one engine at a time. It advances the key on a failed check, and stops on a match or when the key range is exhausted.

## Interface
- KEY_WIDTH, 24, candidate key width in bits
- KEY_FIRST, 24'h000000, first key tried
- KEY_LAST, 24'h3FFFFF, last key tried (inclusive)
- TIMEOUT_CYCLES, 4096, per-phase watchdog limit; used only with the watchdog macro
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin search from KEY_FIRST; sampled only in IDLE, FOUND, EXHAUSTED, ERROR
- key  out  KEY_WIDTH  current candidate; reset KEY_FIRST
- init_start, ksa_start, dec_start  out  1  one-cycle engine start pulses; reset 0
- init_finish, ksa_finish, dec_finish  in  1  engine done; level or pulse, first high cycle in the wait state counts
- dec_match  in  1  decrypt result valid; sampled on the same cycle as dec_finish
- init_addr/ksa_addr/dec_addr  in  8  engine S address requests
- init_data/ksa_data/dec_data  in  8  engine S write data
- init_wren/ksa_wren/dec_wren  in  1  engine S write enables
- s_address, s_data  out  8  granted S-port address/data; 0 when no owner
- s_wren  out  1  granted write enable; 0 when no owner
- busy  out  1  high in any GO/WAIT/NEXT_KEY state; reset 0
- found, exhausted  out  1  level status, held until next start or reset; reset 0
- err  out  1  watchdog fault level; reset 0

## Operation
- States: IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, DEC_GO, DEC_WAIT, NEXT_KEY, FOUND, EXHAUSTED, ERROR.
- IDLE/FOUND/EXHAUSTED/ERROR + start: key←KEY_FIRST, found/exhausted/err←0, →INIT_GO.
- X_GO: assert X_start for this cycle only, →X_WAIT.
- INIT_WAIT + init_finish →KSA_GO. KSA_WAIT + ksa_finish →DEC_GO.
- DEC_WAIT + dec_finish:
  - dec_match=1 →FOUND, key held.
  - dec_match=0, key==KEY_LAST →EXHAUSTED, key held at KEY_LAST.
  - Otherwise →NEXT_KEY.
- NEXT_KEY: key←key+1 (KEY_WIDTH, no wrap possible), →INIT_GO.
- Port ownership follows phase:
  - init owns the port in INIT_GO/INIT_WAIT; ksa in KSA_*; dec in DEC_*.
  - No owner elsewhere.
  - Mux is combinational from the registered owner.
  - Non-owner wren is ignored, never OR-ed.
- start while busy: ignored.
- finish from a non-current engine: ignored.
- reset at any time: IDLE, all outputs to reset values next edge; an engine mid-write loses the port immediately.

## Timing
- start sampled at edge n → INIT_GO at n+1; init_start high in cycle n+1 only.
- finish high at edge m in X_WAIT → next X_GO (or NEXT_KEY) at m+1; next start pulse in cycle m+1.
- Per-key overhead: 4 cycles (3 GO cycles + NEXT_KEY) plus engine latencies.
- Finish asserted in the GO cycle is not sampled; it is first observed in WAIT.
- found/exhausted set on the edge leaving DEC_WAIT; busy drops the same edge.

## Configuration
- RC4_SCHED_WATCHDOG_EN defined:
  - A 16-bit cycle counter clears on every GO and counts in WAIT.
  - Reaching TIMEOUT_CYCLES-1 without finish →ERROR, err=1, key held.
  - Cleared by start or reset.
- Undefined: no counter, WAIT states wait indefinitely, err tied 0, ERROR unreachable.

## Structure
- rc4_pkg: state enum sched_state_t, owner enum s_owner_t {OWN_NONE, OWN_INIT, OWN_KSA, OWN_DEC}, default key width/bounds constants.
- Sub-module rc4_s_port_mux: combinational 3:1 S-port mux selected by s_owner_t; zero output on OWN_NONE.

## Test plan
- Reset, then start; init/ksa/dec finish after 256/768/64 cycles with dec_match=1 on the first key → found=1, key=0, busy=0, exactly one pulse per start.
- KEY_FIRST=0, KEY_LAST=3, dec_match always 0 → keys 0,1,2,3 tried, then exhausted=1, key=3, four dec_start pulses.
- dec_match=1 on key 2 → found at key 2; start again → key resets to 0, found clears.
- Drive ksa_wren=1, addr=8'hAA during INIT_WAIT → s_wren follows init_wren only; s_address=init_addr; in NEXT_KEY s_address=0, s_wren=0.
- Assert reset during KSA_WAIT with s_wren=1 → next edge IDLE, s_wren=0, key=KEY_FIRST, busy=0.
- With RC4_SCHED_WATCHDOG_EN and TIMEOUT_CYCLES=16, withhold ksa_finish → ERROR 16 cycles after KSA_GO, err=1; start clears err. Without the macro, same stimulus stays in KSA_WAIT with err=0.
